ascon_loader: RTL

ASCON_LOADER -- requirements
Module: ascon_loader

---
 rtl/ascon_pkg.sv | 19 +
 rtl/ascon_loader.sv | 126 ++++++++++++
 2 files changed

// File: rtl/ascon_pkg.sv
// Shared constants for the ASCON operand loader: FSM state encoding and width helper.
// Pure declarations; no timing or flow-control behaviour of its own.
package ascon_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_START = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  function automatic int ascon_max(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/ascon_loader.sv
// Captures a parallel ASCON job and streams its operands MSB-first to a bit-serial core.
// Start strobe rises MAX+1 cycles after acceptance; load_ready stays low until done.
module ascon_loader
  import ascon_pkg::*;
#(
  parameter int K    = 128,
  parameter int L    = 40,
  parameter int Y    = 80,
  parameter int HOLD = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic         decrypt_i,
  input  logic [K-1:0] key_i,
  input  logic [127:0] nonce_i,
  input  logic [L-1:0] ad_i,
  input  logic [Y-1:0] data_i,
  output logic         keyxSI,
  output logic         noncexSI,
  output logic         associated_dataxSI,
  output logic         cipher_textxSI,
  output logic         decryption_startxSI,
  output logic         decrypt,
  input  logic         decryption_readyxSO,
  output logic         done
);

  localparam int MAX = ascon_max(K, 128, L, Y);
  localparam int CW  = $clog2(MAX + 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(MAX - 1);
  localparam logic [CW-1:0] LAST_HOLD = CW'(HOLD - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [K-1:0]  key_q, key_d, key_sh;
  logic [127:0]  nonce_q, nonce_d, nonce_sh;
  logic [L-1:0]  ad_q, ad_d, ad_sh;
  logic [Y-1:0]  data_q, data_d, data_sh;
  logic          mode_q, mode_d;
  logic [3:0]    ser_q, ser_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    nonce_d = nonce_q;
    ad_d    = ad_q;
    data_d  = data_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (load_valid && load_ready) begin
          key_d   = key_i;
          nonce_d = nonce_i;
          ad_d    = ad_i;
          data_d  = data_i;
          mode_d  = decrypt_i;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          state_d = S_START;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      // The shift counter is reused to time the start strobe.
      S_START: begin
        if (cnt_q == LAST_HOLD) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        if (decryption_readyxSO) state_d = S_IDLE;
      end
    endcase
  end

  // Serial bits are selected from next-state values so the output flops line up
  // with SHIFT cycle i; shifting past a stream's width naturally yields 0.
  always_comb begin
    key_sh   = key_d << cnt_d;
    nonce_sh = nonce_d << cnt_d;
    ad_sh    = ad_d << cnt_d;
    data_sh  = data_d << cnt_d;
    ser_d    = (state_d == S_SHIFT) ?
               {key_sh[K-1], nonce_sh[127], ad_sh[L-1], data_sh[Y-1]} : 4'b0000;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      key_q   <= '0;
      nonce_q <= '0;
      ad_q    <= '0;
      data_q  <= '0;
      mode_q  <= 1'b0;
      ser_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      nonce_q <= nonce_d;
      ad_q    <= ad_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      ser_q   <= ser_d;
    end
  end

  assign load_ready          = (state_q == S_IDLE);
  assign decryption_startxSI = (state_q == S_START);
  assign decrypt             = mode_q;
  assign done                = (state_q == S_WAIT) && decryption_readyxSO;
  assign {keyxSI, noncexSI, associated_dataxSI, cipher_textxSI} = ser_q;

endmodule
